// File: rtl/branch_predictor_unit_pkg.sv
// Shared types for the fetch-stage branch predictor: control-flow kinds and 2-bit counter encoding.
// The return-stack option is selected with the BP_RAS_EN macro.
package bp_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } kind_t;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken && cur != CTR_ST) nxt = cur + 2'd1;
        else if (!taken && cur != CTR_SNT) nxt = cur - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_unit_ras.sv
// Circular return-address stack with a non-speculative pointer/count snapshot used to recover after a flush.
// Instantiated by branch_predictor_unit only when BP_RAS_EN is defined.
module bp_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    input  logic            snapshot,
    input  logic            restore,
    output logic [XLEN-1:0] top,
    output logic            valid
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0] stack [DEPTH];
    logic [PTR_W-1:0] ptr, snap_ptr;
    logic [PTR_W:0]   count, snap_count;

    // ptr names the next free slot, so the top lives one below it (wrapping).
    assign top   = stack[ptr - 1'b1];
    assign valid = (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            count      <= '0;
            snap_ptr   <= '0;
            snap_count <= '0;
        end else begin
            if (snapshot) begin
                snap_ptr   <= ptr;
                snap_count <= count;
            end
            if (restore) begin
                ptr   <= snap_ptr;
                count <= snap_count;
            end else if (push) begin
                ptr <= ptr + 1'b1;
                if (count != FULL) count <= count + 1'b1;
            end else if (pop && valid) begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !restore) stack[ptr] <= push_data;
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Next-PC predictor: direct-mapped 2-bit counters plus tagged BTB, trained from execute, with registered redirect.
// Define BP_RAS_EN to add a return-address stack for RET targets.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [1:0]      upd_kind,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);

    ctr_t            ctr        [ENTRIES];
    logic            btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag   [ENTRIES];
    logic [XLEN-1:0] btb_target [ENTRIES];
    kind_t           btb_kind   [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_match, btb_write;
    kind_t            f_kind, u_kind;
    logic [XLEN-1:0]  f_seq, u_seq, actual, predicted;

    assign f_idx  = fetch_pc[IDX_W-1:0];
    assign f_tag  = fetch_pc[IDX_W+TAG_W-1:IDX_W];
    assign f_hit  = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_kind = btb_kind[f_idx];
    assign f_seq  = fetch_pc + 1'b1;

    assign u_idx   = upd_pc[IDX_W-1:0];
    assign u_tag   = upd_pc[IDX_W+TAG_W-1:IDX_W];
    assign u_kind  = kind_t'(upd_kind);
    assign u_match = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    assign u_seq   = upd_pc + 1'b1;

    assign actual    = upd_taken ? upd_target : u_seq;
    assign predicted = upd_pred_taken ? upd_pred_target : u_seq;

    // A not-taken COND that misses still claims the entry so its counter has an owner.
    assign btb_write = upd_valid && (upd_taken || (u_kind == BR_COND && !u_match));

`ifdef BP_RAS_EN
    logic            ras_valid;
    logic [XLEN-1:0] ras_top;

    bp_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (fetch_valid && f_hit && f_kind == BR_CALL),
        .pop       (fetch_valid && f_hit && f_kind == BR_RET),
        .push_data (f_seq),
        .snapshot  (upd_valid),
        .restore   (mispredict),
        .top       (ras_top),
        .valid     (ras_valid)
    );
`endif

    always_comb begin
        pred_taken  = f_hit && (f_kind != BR_COND || ctr[f_idx][1]);
        pred_target = f_seq;
        if (pred_taken) begin
            pred_target = btb_target[f_idx];
`ifdef BP_RAS_EN
            if (f_kind == BR_RET && ras_valid) pred_target = ras_top;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i]       <= CTR_WNT;
                btb_valid[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (u_kind == BR_COND) begin
                if (u_match) ctr[u_idx] <= ctr_next(ctr[u_idx], upd_taken);
                else         ctr[u_idx] <= upd_taken ? CTR_WT : CTR_WNT;
            end
            if (btb_write) btb_valid[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && btb_write) begin
            btb_tag[u_idx]    <= u_tag;
            btb_kind[u_idx]   <= u_kind;
            btb_target[u_idx] <= actual;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            mispredict <= upd_valid && (actual != predicted);
            if (upd_valid) redirect_pc <= actual;
            if (upd_valid && (actual != predicted) && mispredict_cnt != 32'hFFFF_FFFF)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench for branch_predictor_unit; RAS scenarios run only when BP_RAS_EN is defined.
module tb_branch_predictor_unit;
    import bp_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_kind;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] mispredict_cnt;

    logic [32:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;

    branch_predictor_unit dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_kind        (upd_kind),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .mispredict_cnt  (mispredict_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        check("pred_taken", 64'(pred_taken), 64'(exp_tk));
        check("pred_target", 64'(pred_target), 64'(exp_tgt));
    endtask

    task automatic drive_upd(input logic [31:0] pc, input kind_t k, input logic tk, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt);
        logic [31:0] act, prd;
        logic        m;
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_kind        = k;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        act = tk  ? tgt  : pc + 32'd1;
        prd = ptk ? ptgt : pc + 32'd1;
        m   = (act != prd);
        if (m && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        exp_q.push_back({m, act});
    endtask

    task automatic finish_upd();
        logic [32:0] e;
        @(posedge clock);
        #1 upd_valid = 1'b0;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("mispredict", 64'(mispredict), 64'(e[32]));
            if (e[32]) check("redirect_pc", 64'(redirect_pc), 64'(e[31:0]));
            check("mispredict_cnt", 64'(mispredict_cnt), 64'(exp_cnt));
        end
    endtask

    task automatic do_upd(input logic [31:0] pc, input kind_t k, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        drive_upd(pc, k, tk, tgt, ptk, ptgt);
        finish_upd();
    endtask

    task automatic step(input logic [31:0] pc);
        fetch_pc    = pc;
        fetch_valid = 1'b1;
        @(posedge clock);
        #1 fetch_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_kind = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);

        check("reset_mispredict", 64'(mispredict), 64'd0);
        check("reset_cnt", 64'(mispredict_cnt), 64'd0);
        lookup(32'h10, 1'b0, 32'h11);

        // first taken COND allocates at WT and mispredicts
        do_upd(32'h10, BR_COND, 1'b1, 32'h40, 1'b0, 32'h0);
        lookup(32'h10, 1'b1, 32'h40);
        @(negedge clock);
        check("mispredict_pulse", 64'(mispredict), 64'd0);

        repeat (3) do_upd(32'h10, BR_COND, 1'b1, 32'h40, 1'b1, 32'h40);
        do_upd(32'h10, BR_COND, 1'b0, 32'h0, 1'b1, 32'h40);
        lookup(32'h10, 1'b1, 32'h40);
        do_upd(32'h10, BR_COND, 1'b0, 32'h0, 1'b1, 32'h40);
        lookup(32'h10, 1'b0, 32'h11);

        // alias eviction: 0x50 shares index 0x10 with a different tag
        do_upd(32'h10, BR_COND, 1'b1, 32'h40, 1'b0, 32'h0);
        lookup(32'h10, 1'b1, 32'h40);
        do_upd(32'h50, BR_JUMP, 1'b1, 32'h99, 1'b0, 32'h0);
        lookup(32'h50, 1'b1, 32'h99);
        lookup(32'h10, 1'b0, 32'h11);

        do_upd(32'h20, BR_COND, 1'b1, 32'h30, 1'b1, 32'h30);
        do_upd(32'hFFFF_FFFF, BR_COND, 1'b0, 32'h0, 1'b0, 32'h0);
        do_upd(32'hFFFF_FFFF, BR_COND, 1'b0, 32'h0, 1'b1, 32'h1234);
        lookup(32'hFFFF_FFFF, 1'b0, 32'h0);

        // lookup during an update to the same index sees the old contents
        fetch_pc = 32'h5;
        drive_upd(32'h5, BR_COND, 1'b1, 32'h77, 1'b0, 32'h0);
        #1;
        check("same_cycle_taken", 64'(pred_taken), 64'd0);
        check("same_cycle_target", 64'(pred_target), 64'h6);
        finish_upd();
        lookup(32'h5, 1'b1, 32'h77);

        do_upd(32'h08, BR_CALL, 1'b1, 32'h100, 1'b0, 32'h0);
        lookup(32'h08, 1'b1, 32'h100);
        do_upd(32'h105, BR_RET, 1'b1, 32'hAA, 1'b0, 32'h0);
        lookup(32'h105, 1'b1, 32'hAA);

`ifdef BP_RAS_EN
        for (int i = 0; i < 9; i++) do_upd(32'h30 + 32'(i), BR_CALL, 1'b1, 32'h300, 1'b0, 32'h0);
        step(32'h08);
        lookup(32'h105, 1'b1, 32'h09);
        step(32'h105);
        for (int i = 0; i < 9; i++) step(32'h30 + 32'(i));
        for (int j = 0; j < 8; j++) begin
            lookup(32'h105, 1'b1, 32'h39 - 32'(j));
            step(32'h105);
        end
        lookup(32'h105, 1'b1, 32'hAA);
`endif

        for (int i = 0; i < 40; i++) begin
            kind_t       k;
            logic        tk, ptk;
            logic [31:0] tgt, ptgt;
            k    = kind_t'($urandom_range(0, 3));
            tk   = (k != BR_COND) ? 1'b1 : 1'($urandom_range(0, 1));
            tgt  = $urandom;
            ptk  = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 1) != 0) ? tgt : $urandom;
            do_upd($urandom, k, tk, tgt, ptk, ptgt);
        end

        // reset overrides a concurrent mispredicting update
        drive_upd(32'h10, BR_COND, 1'b1, 32'h40, 1'b0, 32'h0);
        void'(exp_q.pop_back());
        exp_cnt = 0;
        reset = 1'b1;
        @(posedge clock);
        #1 begin reset = 1'b0; upd_valid = 1'b0; end
        @(negedge clock);
        check("reset_upd_mispredict", 64'(mispredict), 64'd0);
        check("reset_upd_redirect", 64'(redirect_pc), 64'd0);
        check("reset_upd_cnt", 64'(mispredict_cnt), 64'd0);
        lookup(32'h10, 1'b0, 32'h11);
        lookup(32'h50, 1'b0, 32'h51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
